// File: rtl/column_buffer_manager.sv
// Avalon-MM slave managing three column buffers (display / write / pending).
// Builds 28-bit column words from HI/LO bus writes and rotates buffers at frame end and vblank.
module column_buffer_manager #(
    parameter int NUM_COLS = 640,
    parameter int COL_W    = 28
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipselect,
    input  logic             write,
    input  logic             read,
    input  logic [1:0]       address,
    input  logic [15:0]      writedata,
    output logic [15:0]      readdata,
    input  logic             vblank_start,
    output logic             wr_en,
    output logic [1:0]       wr_sel,
    output logic [9:0]       wr_col,
    output logic [COL_W-1:0] wr_data,
    output logic [1:0]       rd_sel,
    output logic             irq
);

    typedef enum logic {
        STAGE_HI = 1'b0,
        STAGE_LO = 1'b1
    } stage_t;

    stage_t      stage;
    stage_t      stage_next;
    logic [1:0]  wr_idx;
    logic        pend_valid;
    logic [9:0]  col_cnt;
    logic [12:0] hi;
    logic [15:0] framecnt;

    logic        data_wr;
    logic        abort;
    logic        lo_accept;
    logic        frame_done;
    logic        show_frame;
    logic        irq_clear;
    logic [1:0]  pend_sel;

    assign data_wr    = chipselect && write && (address == 2'd0);
    assign abort      = chipselect && write && (address == 2'd1) && writedata[0];
    assign lo_accept  = data_wr && !abort && (stage == STAGE_LO);
    assign frame_done = lo_accept && (col_cnt == 10'(NUM_COLS - 1));
    assign show_frame = vblank_start && (frame_done || pend_valid);
    assign irq_clear  = chipselect && read && (address == 2'd2);
    // The pending buffer is whichever index is neither displayed nor being written.
    assign pend_sel   = 2'd3 ^ wr_idx ^ rd_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage <= STAGE_HI;
        end else begin
            stage <= stage_next;
        end
    end

    always_comb begin
        stage_next = stage;
        if (abort) begin
            stage_next = STAGE_HI;
        end else if (data_wr) begin
            case (stage)
                STAGE_HI: stage_next = STAGE_LO;
                STAGE_LO: stage_next = STAGE_HI;
                default:  stage_next = STAGE_HI;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi      <= '0;
            col_cnt <= '0;
            wr_en   <= 1'b0;
            wr_sel  <= 2'd0;
            wr_col  <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= lo_accept;
            if (data_wr && !abort && (stage == STAGE_HI)) begin
                hi <= writedata[12:0];
            end
            if (lo_accept) begin
                wr_sel  <= wr_idx;
                wr_col  <= col_cnt;
                wr_data <= {hi, writedata[14:0]};
            end
            // Abort restarts the current buffer from column zero without rotating.
            if (abort || frame_done) begin
                col_cnt <= '0;
            end else if (lo_accept) begin
                col_cnt <= col_cnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_sel     <= 2'd0;
            wr_idx     <= 2'd1;
            pend_valid <= 1'b0;
            framecnt   <= '0;
            irq        <= 1'b0;
        end else begin
            // A frame finishing on the vblank cycle goes straight to display.
            if (frame_done && vblank_start) begin
                rd_sel     <= wr_idx;
                wr_idx     <= pend_sel;
                pend_valid <= 1'b0;
                framecnt   <= framecnt + 16'd1;
            end else if (frame_done) begin
                wr_idx     <= pend_sel;
                pend_valid <= 1'b1;
            end else if (vblank_start && pend_valid) begin
                rd_sel     <= pend_sel;
                pend_valid <= 1'b0;
                framecnt   <= framecnt + 16'd1;
            end
            if (show_frame) begin
                irq <= 1'b1;
            end else if (irq_clear) begin
                irq <= 1'b0;
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd2:    readdata = {2'b00, col_cnt, (stage == STAGE_LO), pend_valid, irq, 1'b0};
            2'd3:    readdata = framecnt;
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_column_buffer_manager.sv
// Self-checking bench for column_buffer_manager: directed frame scenarios plus random
// bus traffic compared against a behavioural buffer-ownership model.
module tb_column_buffer_manager;

    localparam int NUM_COLS = 640;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [1:0]  address = 2'd0;
    logic [15:0] writedata = 16'd0;
    logic        vblank_start = 1'b0;
    logic [15:0] readdata;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [9:0]  wr_col;
    logic [27:0] wr_data;
    logic [1:0]  rd_sel;
    logic        irq;

    int total = 0;
    int bad = 0;

    // Reference model: which buffer holds what, plus the bus-visible counters
    int          m_rd, m_wr, m_col, m_fc;
    bit          m_pend, m_lo, m_irq;
    logic [12:0] m_hi;
    bit          e_en;
    int          e_sel, e_col;
    logic [27:0] e_data;

    column_buffer_manager #(.NUM_COLS(NUM_COLS), .COL_W(28)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
        .address(address), .writedata(writedata), .readdata(readdata),
        .vblank_start(vblank_start), .wr_en(wr_en), .wr_sel(wr_sel), .wr_col(wr_col),
        .wr_data(wr_data), .rd_sel(rd_sel), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int spareOf(input int a, input int b);
        for (int i = 0; i < 3; i++) begin
            if (i != a && i != b) return i;
        end
        return 0;
    endfunction

    function automatic logic [15:0] expectedRead(input logic [1:0] addr);
        logic [15:0] v;
        v = 16'd0;
        if (addr == 2'd2) v = {2'b00, 10'(m_col), m_lo, m_pend, m_irq, 1'b0};
        else if (addr == 2'd3) v = 16'(m_fc);
        return v;
    endfunction

    task automatic modelReset();
        m_rd = 0; m_wr = 1; m_col = 0; m_fc = 0;
        m_pend = 0; m_lo = 0; m_irq = 0; m_hi = '0;
        e_en = 0; e_sel = 0; e_col = 0; e_data = '0;
    endtask

    task automatic modelStep(input bit cs, input bit we, input bit re, input logic [1:0] addr,
                             input logic [15:0] wd, input bit vb);
        bit complete, shown;
        int spare;
        complete = 0;
        shown = 0;
        e_en = 0;
        spare = spareOf(m_rd, m_wr);
        if (cs && we && addr == 2'd1 && wd[0]) begin
            m_col = 0;
            m_lo = 0;
        end else if (cs && we && addr == 2'd0) begin
            if (!m_lo) begin
                m_hi = wd[12:0];
                m_lo = 1;
            end else begin
                e_en = 1; e_sel = m_wr; e_col = m_col; e_data = {m_hi, wd[14:0]};
                m_lo = 0;
                if (m_col == NUM_COLS - 1) begin
                    complete = 1;
                    m_col = 0;
                end else begin
                    m_col++;
                end
            end
        end
        if (complete && vb) begin
            m_rd = m_wr; m_wr = spare; m_pend = 0; m_fc++; shown = 1;
        end else if (complete) begin
            m_wr = spare; m_pend = 1;
        end else if (vb && m_pend) begin
            m_rd = spare; m_pend = 0; m_fc++; shown = 1;
        end
        if (shown) m_irq = 1;
        else if (cs && re && addr == 2'd2) m_irq = 0;
    endtask

    task automatic checkAll();
        checkOutput("wr_en", 32'(wr_en), 32'(e_en));
        checkOutput("wr_sel", 32'(wr_sel), 32'(e_sel));
        checkOutput("wr_col", 32'(wr_col), 32'(e_col));
        checkOutput("wr_data", 32'(wr_data), 32'(e_data));
        checkOutput("rd_sel", 32'(rd_sel), 32'(m_rd));
        checkOutput("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic applyStimulus(input bit cs, input bit we, input bit re, input logic [1:0] addr,
                                 input logic [15:0] wd, input bit vb);
        chipselect = cs; write = we; read = re; address = addr; writedata = wd; vblank_start = vb;
        #1;
        checkOutput("readdata", 32'(readdata), 32'(expectedRead(addr)));
        @(posedge clk);
        #1;
        modelStep(cs, we, re, addr, wd, vb);
        checkAll();
        chipselect = 0; write = 0; read = 0; vblank_start = 0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        #1;
        modelReset();
        checkAll();
        checkOutput("rst_readdata", 32'(readdata), 32'(expectedRead(address)));
        @(posedge clk);
        #1;
        checkAll();
        reset = 1'b0;
        #1;
    endtask

    task automatic writeCol(input logic [15:0] hv, input logic [15:0] lv, input bit vb);
        applyStimulus(1, 1, 0, 2'd0, hv, 0);
        applyStimulus(1, 1, 0, 2'd0, lv, vb);
    endtask

    task automatic writeCols(input int n);
        for (int c = 0; c < n; c++) begin
            writeCol(16'(c), ~16'(c), 0);
        end
    endtask

    task automatic peek(input string tag, input logic [1:0] addr, input logic [15:0] exp);
        address = addr;
        #1;
        checkOutput(tag, 32'(readdata), 32'(exp));
    endtask

    initial begin
        #2;
        doReset();
        peek("rst_status", 2'd2, 16'h0000);
        peek("rst_fc", 2'd3, 16'h0000);

        // Full frame into buffer 1, then show it at vblank
        writeCols(NUM_COLS);
        checkOutput("p1_last_col", 32'(wr_col), 32'd639);
        checkOutput("p1_sel", 32'(wr_sel), 32'd1);
        checkOutput("p1_rd", 32'(rd_sel), 32'd0);
        peek("p1_status", 2'd2, 16'h0004);
        applyStimulus(0, 0, 0, 2'd0, 16'd0, 1);
        checkOutput("p2_rd", 32'(rd_sel), 32'd1);
        checkOutput("p2_irq", 32'(irq), 32'd1);
        peek("p2_fc", 2'd3, 16'd1);
        peek("p2_status", 2'd2, 16'h0002);
        applyStimulus(1, 0, 1, 2'd2, 16'd0, 0);
        checkOutput("p2_irq_clr", 32'(irq), 32'd0);

        // Two frames before a vblank: the older one is dropped
        writeCols(NUM_COLS);
        checkOutput("p3_first_sel", 32'(wr_sel), 32'd2);
        writeCols(NUM_COLS);
        checkOutput("p3_second_sel", 32'(wr_sel), 32'd0);
        applyStimulus(0, 0, 0, 2'd0, 16'd0, 1);
        checkOutput("p3_rd", 32'(rd_sel), 32'd0);
        peek("p3_fc", 2'd3, 16'd2);
        writeCol(16'h1234, 16'h5678, 0);
        checkOutput("p3_next_sel", 32'(wr_sel), 32'd2);

        // Final LO write coincident with vblank
        doReset();
        writeCols(NUM_COLS - 1);
        writeCol(16'd639, ~16'd639, 1);
        checkOutput("p4_rd", 32'(rd_sel), 32'd1);
        checkOutput("p4_irq", 32'(irq), 32'd1);
        peek("p4_status", 2'd2, 16'h0002);
        writeCol(16'd7, 16'd9, 0);
        checkOutput("p4_next_sel", 32'(wr_sel), 32'd2);

        // Abort mid-frame restarts the column count
        doReset();
        writeCols(300);
        applyStimulus(1, 1, 0, 2'd1, 16'h0001, 0);
        writeCol(16'h0abc, 16'h0def, 0);
        checkOutput("p5_restart_col", 32'(wr_col), 32'd0);
        for (int c = 1; c < NUM_COLS; c++) writeCol(16'(c), ~16'(c), 0);
        peek("p5_status", 2'd2, 16'h0004);
        checkOutput("p5_rd", 32'(rd_sel), 32'd0);

        // Reset with a pending frame and a half-written column
        writeCols(100);
        applyStimulus(1, 1, 0, 2'd0, 16'h1fff, 0);
        doReset();
        checkOutput("p6_wr_en", 32'(wr_en), 32'd0);
        checkOutput("p6_rd", 32'(rd_sel), 32'd0);
        peek("p6_status", 2'd2, 16'h0000);
        applyStimulus(1, 1, 0, 2'd0, 16'h7fff, 0);
        checkOutput("p6_no_wr", 32'(wr_en), 32'd0);
        peek("p6_stage_lo", 2'd2, 16'h0008);

        // Random bus traffic
        for (int n = 0; n < 6000; n++) begin
            int r;
            bit vb;
            logic [15:0] wd;
            r = $urandom_range(0, 199);
            vb = ($urandom_range(0, 99) == 0);
            wd = 16'($urandom);
            if (r < 160) applyStimulus(1, 1, 0, 2'd0, wd, vb);
            else if (r < 163) applyStimulus(1, 1, 0, 2'd1, wd & 16'hfffe, vb);
            else if (r == 163) applyStimulus(1, 1, 0, 2'd1, wd | 16'h0001, vb);
            else if (r < 170) applyStimulus(1, 1, 0, 2'($urandom_range(2, 3)), wd, vb);
            else if (r < 180) applyStimulus(1, 0, 1, 2'($urandom_range(0, 3)), wd, vb);
            else if (r < 185) applyStimulus(0, 1, 1, 2'($urandom_range(0, 3)), wd, vb);
            else applyStimulus(0, 0, 0, 2'($urandom_range(0, 3)), wd, vb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
